hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
Pipeline hazard controller for the 5-stage 64-bit LEGv8 core. It sits beside the instruction decoder and tracks the destination registers of the instructions in EX, MEM and WB. Each cycle it generates the load-use stall, the branch flush, and the registered operand-forwarding selects that drive the EX-stage ALU input muxes. It also keeps a saturating stall counter for performance debug.

Parameters:
REG_AW, 5, register-address width.
ZERO_REG, 31, index of XZR; never a hazard source and never forwarded.
CNT_W, 16, width of stall_count.

Ports:
clk  input  1  core clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
id_valid  input  1  ID stage holds a real instruction.
id_rn  input  REG_AW  first source register (instr[9:5]).
id_rm  input  REG_AW  second source register, Rm or Rt per Reg2Loc.
id_use_rn  input  1  ID instruction reads rn.
id_use_rm  input  1  ID instruction reads rm. Low for immediates and B.
id_rd  input  REG_AW  destination register (instr[4:0]).
id_regwri  input  1  RegWri from decode.
id_readmem  input  1  asserted for LDUR only; STUR drives 0 here.
br_taken  input  1  taken branch resolved in ID (B, or CBZ with zero=1).
stall  output  1  hold PC and IF/ID register, and insert a bubble into EX.
flush  output  1  squash the instruction currently in IF.
fwd_a  output  2  EX operand-A select: 00 = register file, 01 = EX/MEM result, 10 = MEM/WB result.
fwd_b  output  2  EX operand-B select, same encoding as fwd_a.
stall_count  output  CNT_W  number of stall cycles since reset; saturates.

Behaviour:
- Tracking state: the three stages EX, MEM and WB each hold a record {v, rd, wr, ld}.
- Per rising edge (not in reset):
  - WB <= MEM and MEM <= EX, unconditionally.
  - EX <= {id_valid, id_rd, id_regwri, id_readmem} when stall = 0. When stall = 1, EX <= bubble (v = 0).
- A stage record "writes r" when v & wr & (rd == r) & (r != ZERO_REG).
- stall (combinational):
  - Asserted when id_valid & EX.v & EX.ld & EX.wr & EX.rd != ZERO_REG, and the ID instruction reads EX.rd through rn (with id_use_rn) or through rm (with id_use_rm).
  - Stall lasts exactly one cycle per load-use pair, because the load has moved to MEM on the next cycle.
- flush (combinational): br_taken & id_valid & ~stall.
  - If stall and br_taken are asserted together, stall wins and flush = 0. The branch stays in ID and is re-evaluated on the next cycle.
- Forwarding (registered; fwd_a and fwd_b belong to the instruction now in EX):
  - Computed at the ID-to-EX transfer for the rn (A) and rm (B) sources, and updated only when stall = 0.
  - If EX (current, moving to MEM) writes the source -> 01.
  - Else if MEM (moving to WB) writes the source -> 10.
  - Else -> 00.
  - The youngest producer wins.
  - A source whose use bit is 0 gets 00.
  - On stall, fwd_a and fwd_b are set to 00 (the bubble in EX).
  - The instruction released after a load-use stall gets 10 from the load's MEM record.
- WB-stage producers are not forwarded. The register file writes before it reads within a cycle.
- stall_count: increments on every cycle with stall = 1 and saturates at all ones.
- Reset (synchronous, also mid-operation): on the next rising edge with reset = 1, all v <= 0, fwd_a = fwd_b = 00, stall_count = 0. stall and flush evaluate to 0 while the tracking state is all invalid and id_valid = 0.

Test Plan:
- Load-use hazard: LDUR X1,[X2,#0] then ADDS X3,X1,X4 -> stall = 1 for exactly one cycle. The ADDS reaches EX with fwd_a = 10, fwd_b = 00. stall_count = 1.
- Back-to-back ALU chain: ADDI X5,X0,#1; ADDI X6,X5,#2; ADDS X7,X5,X6 -> no stall. Second instruction fwd_a = 01. Third instruction fwd_a = 10, fwd_b = 01.
- XZR and immediates: LDUR X31,[X0,#0] then ADDS X1,X31,X31 -> stall = 0, fwd = 00. SUBI X2,X1,#4 with X1 produced one cycle earlier -> fwd_a = 01, fwd_b = 00.
- Branch flush: B taken with no hazard -> flush = 1 for one cycle. CBZ X1 directly after LDUR X1 with br_taken = 1 -> cycle 1 stall = 1, flush = 0; cycle 2 stall = 0, flush = 1.
- Reset mid-stream: assert reset during a pending load-use pair -> after the edge, stall = 0, fwd = 00, stall_count = 0. The first ADDS after reset sees no stale forwarding.
- Saturation: CNT_W = 4 with 20 load-use pairs -> stall_count holds at 15.

Source files
------------

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl
// Purpose  : LEGv8 5-stage pipeline hazard unit: load-use stall, branch flush,
//            registered EX operand-forwarding selects and a stall counter.
// Revision : 1.0
// ============================================================================
module hazard_ctrl #(
    parameter int REG_AW   = 5,
    parameter int ZERO_REG = 31,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rn,
    input  logic [REG_AW-1:0] id_rm,
    input  logic              id_use_rn,
    input  logic              id_use_rm,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_regwri,
    input  logic              id_readmem,
    input  logic              br_taken,
    output logic              stall,
    output logic              flush,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [CNT_W-1:0]  stall_count
);

    localparam logic [REG_AW-1:0] c_zero_reg  = REG_AW'(ZERO_REG);
    localparam logic [1:0]        c_fwd_rf    = 2'b00;
    localparam logic [1:0]        c_fwd_exmem = 2'b01;
    localparam logic [1:0]        c_fwd_memwb = 2'b10;
    localparam logic [CNT_W-1:0]  c_cnt_max   = {CNT_W{1'b1}};

    // The WB record is not kept: the register file writes before it reads,
    // so a WB producer never needs forwarding and never causes a stall.
    logic              r_ex_v;
    logic [REG_AW-1:0] r_ex_rd;
    logic              r_ex_wr;
    logic              r_ex_ld;
    logic              r_mem_v;
    logic [REG_AW-1:0] r_mem_rd;
    logic              r_mem_wr;
    logic [1:0]        r_fwd_a;
    logic [1:0]        r_fwd_b;
    logic [CNT_W-1:0]  r_stall_count;

    logic       w_ex_hit_rn;
    logic       w_ex_hit_rm;
    logic       w_mem_hit_rn;
    logic       w_mem_hit_rm;
    logic       w_stall;
    logic       w_flush;
    logic [1:0] w_fwd_a_nxt;
    logic [1:0] w_fwd_b_nxt;

    // A stage "writes r" only for a valid, register-writing record whose
    // destination is not XZR.
    assign w_ex_hit_rn  = r_ex_v  & r_ex_wr  & (r_ex_rd  == id_rn) & (id_rn != c_zero_reg);
    assign w_ex_hit_rm  = r_ex_v  & r_ex_wr  & (r_ex_rd  == id_rm) & (id_rm != c_zero_reg);
    assign w_mem_hit_rn = r_mem_v & r_mem_wr & (r_mem_rd == id_rn) & (id_rn != c_zero_reg);
    assign w_mem_hit_rm = r_mem_v & r_mem_wr & (r_mem_rd == id_rm) & (id_rm != c_zero_reg);

    assign w_stall = id_valid & r_ex_ld &
                     ((id_use_rn & w_ex_hit_rn) | (id_use_rm & w_ex_hit_rm));
    assign w_flush = br_taken & id_valid & ~w_stall;

    // Youngest producer wins; during a stall the EX slot gets a bubble.
    always_comb begin
        w_fwd_a_nxt = c_fwd_rf;
        w_fwd_b_nxt = c_fwd_rf;
        if (!w_stall) begin
            if (id_use_rn) begin
                if (w_ex_hit_rn)       w_fwd_a_nxt = c_fwd_exmem;
                else if (w_mem_hit_rn) w_fwd_a_nxt = c_fwd_memwb;
            end
            if (id_use_rm) begin
                if (w_ex_hit_rm)       w_fwd_b_nxt = c_fwd_exmem;
                else if (w_mem_hit_rm) w_fwd_b_nxt = c_fwd_memwb;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ex_v        <= 1'b0;
            r_ex_rd       <= '0;
            r_ex_wr       <= 1'b0;
            r_ex_ld       <= 1'b0;
            r_mem_v       <= 1'b0;
            r_mem_rd      <= '0;
            r_mem_wr      <= 1'b0;
            r_fwd_a       <= c_fwd_rf;
            r_fwd_b       <= c_fwd_rf;
            r_stall_count <= '0;
        end else begin
            r_mem_v  <= r_ex_v;
            r_mem_rd <= r_ex_rd;
            r_mem_wr <= r_ex_wr;
            if (w_stall) begin
                r_ex_v  <= 1'b0;
                r_ex_wr <= 1'b0;
                r_ex_ld <= 1'b0;
                if (r_stall_count != c_cnt_max) begin
                    r_stall_count <= r_stall_count + 1'b1;
                end
            end else begin
                r_ex_v  <= id_valid;
                r_ex_rd <= id_rd;
                r_ex_wr <= id_regwri;
                r_ex_ld <= id_readmem;
            end
            r_fwd_a <= w_fwd_a_nxt;
            r_fwd_b <= w_fwd_b_nxt;
        end
    end

    assign stall       = w_stall;
    assign flush       = w_flush;
    assign fwd_a       = r_fwd_a;
    assign fwd_b       = r_fwd_b;
    assign stall_count = r_stall_count;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// Self-checking bench for hazard_ctrl: directed LEGv8 sequences with literal
// expectations, then random traffic against an instruction-level pipeline model.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid, id_use_rn, id_use_rm, id_regwri, id_readmem, br_taken;
    logic [4:0] id_rn, id_rm, id_rd;
    logic       stall, flush, stall4, flush4;
    logic [1:0] fwd_a, fwd_b, fwd_a4, fwd_b4;
    logic [15:0] stall_count;
    logic [3:0]  stall_count4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_ctrl dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rn(id_rn), .id_rm(id_rm),
        .id_use_rn(id_use_rn), .id_use_rm(id_use_rm), .id_rd(id_rd),
        .id_regwri(id_regwri), .id_readmem(id_readmem), .br_taken(br_taken),
        .stall(stall), .flush(flush), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .stall_count(stall_count)
    );

    hazard_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rn(id_rn), .id_rm(id_rm),
        .id_use_rn(id_use_rn), .id_use_rm(id_use_rm), .id_rd(id_rd),
        .id_regwri(id_regwri), .id_readmem(id_readmem), .br_taken(br_taken),
        .stall(stall4), .flush(flush4), .fwd_a(fwd_a4), .fwd_b(fwd_b4),
        .stall_count(stall_count4)
    );

    // Instruction-level model: pipe[0]=EX, pipe[1]=MEM, pipe[2]=WB
    typedef struct {
        bit v;
        int rd;
        bit wr;
        bit ld;
    } rec_t;

    rec_t pipe[3];
    int   m_fa, m_fb, m_cnt, m_cnt4;
    bit   model_ready = 1'b0;

    function automatic bit writes(rec_t s, int r);
        return s.v && s.wr && (s.rd == r) && (r != 31);
    endfunction

    function automatic bit model_stall();
        bit reads_load;
        reads_load = pipe[0].ld &&
                     ((id_use_rn && writes(pipe[0], int'(id_rn))) ||
                      (id_use_rm && writes(pipe[0], int'(id_rm))));
        return id_valid && reads_load;
    endfunction

    function automatic int model_fwd(bit use_src, int src);
        if (!use_src)                return 0;
        if (writes(pipe[0], src))    return 1;
        if (writes(pipe[1], src))    return 2;
        return 0;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            foreach (pipe[i]) pipe[i] = '{0, 0, 0, 0};
            m_fa = 0; m_fb = 0; m_cnt = 0; m_cnt4 = 0;
            model_ready = 1'b1;
        end else begin
            bit s;
            s = model_stall();
            m_fa = s ? 0 : model_fwd(id_use_rn, int'(id_rn));
            m_fb = s ? 0 : model_fwd(id_use_rm, int'(id_rm));
            if (s) begin
                if (m_cnt  < 65535) m_cnt++;
                if (m_cnt4 < 15)    m_cnt4++;
            end
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = s ? '{0, 0, 0, 0}
                        : '{id_valid, int'(id_rd), id_regwri, id_readmem};
        end
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (model_ready) begin
            bit es;
            es = model_stall();
            chk("stall",  32'(stall),  32'(es));
            chk("flush",  32'(flush),  32'(br_taken && id_valid && !es));
            chk("fwd_a",  32'(fwd_a),  32'(m_fa));
            chk("fwd_b",  32'(fwd_b),  32'(m_fb));
            chk("stall_count",  32'(stall_count),  32'(m_cnt));
            chk("stall4", 32'(stall4), 32'(es));
            chk("stall_count4", 32'(stall_count4), 32'(m_cnt4));
        end
    end

    task automatic set_id(bit v, int rn, int rm, bit urn, bit urm, int rd, bit wr,
                          bit ld, bit br);
        id_valid  = v;    id_rn = 5'(rn);    id_rm = 5'(rm);
        id_use_rn = urn;  id_use_rm = urm;   id_rd = 5'(rd);
        id_regwri = wr;   id_readmem = ld;   br_taken = br;
    endtask

    task automatic idle();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle();
        tick();
        tick();
        reset = 1'b0;
    endtask

    function automatic int pick_reg();
        int k;
        k = $urandom_range(0, 4);
        return (k == 4) ? 31 : k;
    endfunction

    initial begin
        reset = 1'b0;
        idle();
        do_reset();
        settle();
        chk("reset_stall", 32'(stall), 0);
        chk("reset_flush", 32'(flush), 0);
        chk("reset_fwd_a", 32'(fwd_a), 0);
        chk("reset_count", 32'(stall_count), 0);

        // Load-use: LDUR X1,[X2] ; ADDS X3,X1,X4
        set_id(1, 2, 0, 1, 0, 1, 1, 1, 0); tick();
        set_id(1, 1, 4, 1, 1, 3, 1, 0, 0); settle();
        chk("lu_stall_c1", 32'(stall), 1);
        tick(); settle();
        chk("lu_stall_c2", 32'(stall), 0);
        tick();
        chk("lu_fwd_a", 32'(fwd_a), 2);
        chk("lu_fwd_b", 32'(fwd_b), 0);
        chk("lu_count", 32'(stall_count), 1);

        // ALU chain: ADDI X5,X0,#1 ; ADDI X6,X5,#2 ; ADDS X7,X5,X6
        set_id(1, 0, 0, 1, 0, 5, 1, 0, 0); tick();
        set_id(1, 5, 0, 1, 0, 6, 1, 0, 0); settle();
        chk("chain_stall", 32'(stall), 0);
        tick();
        chk("chain2_fwd_a", 32'(fwd_a), 1);
        set_id(1, 5, 6, 1, 1, 7, 1, 0, 0); tick();
        chk("chain3_fwd_a", 32'(fwd_a), 2);
        chk("chain3_fwd_b", 32'(fwd_b), 1);

        // XZR: LDUR X31,[X0] ; ADDS X1,X31,X31 ; SUBI X2,X1,#4
        set_id(1, 0, 0, 1, 0, 31, 1, 1, 0); tick();
        set_id(1, 31, 31, 1, 1, 1, 1, 0, 0); settle();
        chk("xzr_stall", 32'(stall), 0);
        tick();
        chk("xzr_fwd_a", 32'(fwd_a), 0);
        chk("xzr_fwd_b", 32'(fwd_b), 0);
        set_id(1, 1, 0, 1, 0, 2, 1, 0, 0); tick();
        chk("subi_fwd_a", 32'(fwd_a), 1);
        chk("subi_fwd_b", 32'(fwd_b), 0);

        // Branch: B taken ; LDUR X1 ; CBZ X1 taken
        set_id(1, 0, 0, 0, 0, 0, 0, 0, 1); settle();
        chk("b_flush", 32'(flush), 1);
        tick();
        set_id(1, 2, 0, 1, 0, 1, 1, 1, 0); settle();
        chk("b_flush_one", 32'(flush), 0);
        tick();
        set_id(1, 0, 1, 0, 1, 0, 0, 0, 1); settle();
        chk("cbz_stall_c1", 32'(stall), 1);
        chk("cbz_flush_c1", 32'(flush), 0);
        tick(); settle();
        chk("cbz_stall_c2", 32'(stall), 0);
        chk("cbz_flush_c2", 32'(flush), 1);
        tick();
        idle(); tick();

        // Reset during a pending load-use pair
        set_id(1, 2, 0, 1, 0, 1, 1, 1, 0); tick();
        set_id(1, 1, 4, 1, 1, 3, 1, 0, 0); settle();
        chk("rst_pend_stall", 32'(stall), 1);
        reset = 1'b1;
        tick();
        idle(); settle();
        chk("rst_stall", 32'(stall), 0);
        chk("rst_fwd_a", 32'(fwd_a), 0);
        chk("rst_count", 32'(stall_count), 0);
        reset = 1'b0;
        set_id(1, 1, 4, 1, 1, 3, 1, 0, 0); settle();
        chk("post_rst_stall", 32'(stall), 0);
        tick();
        chk("post_rst_fwd_a", 32'(fwd_a), 0);
        chk("post_rst_fwd_b", 32'(fwd_b), 0);
        idle(); tick(); tick();

        // Saturation: 20 load-use pairs
        do_reset();
        for (int i = 0; i < 20; i++) begin
            set_id(1, 2, 0, 1, 0, 1, 1, 1, 0); tick();
            set_id(1, 1, 4, 1, 1, 3, 1, 0, 0); tick(); tick();
        end
        idle(); tick();
        chk("sat_count16", 32'(stall_count), 20);
        chk("sat_count4", 32'(stall_count4), 15);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 199) == 0);
            set_id($urandom_range(0, 3) != 0, pick_reg(), pick_reg(),
                   $urandom_range(0, 1), $urandom_range(0, 1), pick_reg(),
                   $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                   $urandom_range(0, 4) == 0);
            tick();
        end
        reset = 1'b0;
        idle(); tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
